// File: rtl/dff_mem_if.sv
// dff_mem_if
//   Groups the Tiny Tapeout user pins that dff_mem drives and observes.
//   Signal names match the TT template so the shell can wire them straight through.
//   Signals:
//     ena      tile enable (1 = active)
//     ui_in    [7] = we (1 = write), [6:0] = addr
//     uio_in   write data
//     uo_out   registered read data
//     uio_out  bidirectional pin output values (always 0 from the memory)
//     uio_oe   bidirectional pin output enables (always 0, so every uio pin is an input)
//   Modports:
//     master  drives ena/ui_in/uio_in and observes the outputs (TT shell or testbench)
//     slave   the memory side
interface dff_mem_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/dff_mem.sv
// dff_mem
//   128 x 8 flip-flop RAM for a Tiny Tapeout tile, driven entirely through the TT user pins.
//   A write also loads the written byte into the output register (write-through).
//   A read returns mem[addr] on uo_out one clock after the address is presented.
//   While ena is low the block is frozen: no write happens and uo_out keeps its value.
//   Reset has priority over ena, and a write presented on a reset edge is dropped.
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous, active-high reset
//     bus   dff_mem_if.slave (ena, ui_in, uio_in, uo_out, uio_out, uio_oe)
//
//   Configuration macro DFF_MEM_CLEAR_ON_RESET_EN:
//     defined   - reset also clears all words to 8'h00 in that same edge
//     undefined - memory flops have no reset and keep their contents across reset
module dff_mem #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic      clk,
  input  logic      rst,
  dff_mem_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic              wr_fire;

  assign we      = bus.ui_in[7];
  assign addr    = bus.ui_in[ADDR_W-1:0];
  assign wr_fire = bus.ena & we;

`ifdef DFF_MEM_CLEAR_ON_RESET_EN
  // Clearing every word in one edge means each memory flop carries a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_fire) begin
      mem[addr] <= bus.uio_in;
    end
  end
`else
  // No reset on the storage; rst only blocks a write landing on the reset edge.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) begin
      mem[addr] <= bus.uio_in;
    end
  end
`endif

  // A write forwards the incoming byte instead of the old array contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (bus.ena) begin
      if (we) begin
        rd_data <= bus.uio_in;
      end else begin
        rd_data <= mem[addr];
      end
    end
  end

  assign bus.uo_out  = rd_data;
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

endmodule

// File: tb/tb_dff_mem.sv
// tb_dff_mem
//   Directed testbench for dff_mem: a table of {inputs, expected uo_out} records applied
//   one clock each, plus hand-written sequences for reset priority, a write colliding
//   with reset, and a full address sweep. Works with and without DFF_MEM_CLEAR_ON_RESET_EN.
module tb_dff_mem;

  logic clk;
  logic rst;

  dff_mem_if bus ();

  dff_mem dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ena;
    logic       we;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_fail;

  function automatic void add_vec(input logic r, input logic e, input logic w,
                                  input logic [6:0] a, input logic [7:0] d,
                                  input logic [7:0] x, input string nm);
    vec_t v;
    v.rst   = r;
    v.ena   = e;
    v.we    = w;
    v.addr  = a;
    v.wdata = d;
    v.exp   = x;
    v.name  = nm;
    vecs.push_back(v);
  endfunction

  // Drives one cycle of inputs, lets the edge happen, then settles 1 time unit past it.
  task automatic apply_stimulus(input logic r, input logic e, input logic w,
                                input logic [6:0] a, input logic [7:0] d);
    rst        = r;
    bus.ena    = e;
    bus.ui_in  = {w, a};
    bus.uio_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %02h, expected %02h", nm, act, exp);
    end
  endtask

  logic [7:0] pattern;

  initial begin
    n_vec  = 0;
    n_fail = 0;

    // ena held low during reset to show reset wins over the enable.
    apply_stimulus(1'b1, 1'b0, 1'b0, 7'h00, 8'h00);
    apply_stimulus(1'b1, 1'b0, 1'b0, 7'h00, 8'h00);
    check_output("reset uo_out", bus.uo_out, 8'h00);
    check_output("reset uio_out", bus.uio_out, 8'h00);
    check_output("reset uio_oe", bus.uio_oe, 8'h00);
    rst = 1'b0;

`ifdef DFF_MEM_CLEAR_ON_RESET_EN
    apply_stimulus(1'b0, 1'b1, 1'b0, 7'h00, 8'h00);
    check_output("clear read 00", bus.uo_out, 8'h00);
    apply_stimulus(1'b0, 1'b1, 1'b0, 7'h3F, 8'h00);
    check_output("clear read 3F", bus.uo_out, 8'h00);
    apply_stimulus(1'b0, 1'b1, 1'b0, 7'h7F, 8'h00);
    check_output("clear read 7F", bus.uo_out, 8'h00);
`endif

    //       rst   ena   we    addr   data   exp
    add_vec(1'b0, 1'b1, 1'b1, 7'h00, 8'hA5, 8'hA5, "wr A5@00");
    add_vec(1'b0, 1'b1, 1'b1, 7'h7F, 8'h3C, 8'h3C, "wr 3C@7F");
    add_vec(1'b0, 1'b1, 1'b0, 7'h00, 8'h00, 8'hA5, "rd 00");
    add_vec(1'b0, 1'b1, 1'b0, 7'h7F, 8'h00, 8'h3C, "rd 7F");
    add_vec(1'b0, 1'b1, 1'b1, 7'h10, 8'h5A, 8'h5A, "wt 5A@10");
    add_vec(1'b0, 1'b1, 1'b1, 7'h10, 8'hC3, 8'hC3, "wt C3@10");
    add_vec(1'b0, 1'b1, 1'b0, 7'h00, 8'h00, 8'hA5, "rd 00 again");
    add_vec(1'b0, 1'b1, 1'b0, 7'h10, 8'h00, 8'hC3, "rd 10");
    add_vec(1'b0, 1'b1, 1'b1, 7'h01, 8'h11, 8'h11, "wr 11@01");
    add_vec(1'b0, 1'b0, 1'b1, 7'h01, 8'hFF, 8'h11, "ena0 wr FF@01");
    add_vec(1'b0, 1'b0, 1'b0, 7'h7F, 8'h00, 8'h11, "ena0 rd holds");
    add_vec(1'b0, 1'b1, 1'b0, 7'h01, 8'h00, 8'h11, "rd 01 not FF");
    add_vec(1'b0, 1'b1, 1'b0, 7'h7F, 8'h00, 8'h3C, "rd 7F again");

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].rst, vecs[i].ena, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check_output(vecs[i].name, bus.uo_out, vecs[i].exp);
      check_output({vecs[i].name, " uio_oe"}, bus.uio_oe, 8'h00);
    end

    // Reset beats a simultaneous write and a low enable.
    apply_stimulus(1'b0, 1'b1, 1'b1, 7'h20, 8'h99);
    check_output("wr 99@20", bus.uo_out, 8'h99);
    apply_stimulus(1'b1, 1'b1, 1'b1, 7'h20, 8'h77);
    check_output("rst+wr uo_out", bus.uo_out, 8'h00);
    check_output("rst uio_out", bus.uio_out, 8'h00);
    apply_stimulus(1'b0, 1'b1, 1'b0, 7'h20, 8'h00);
`ifdef DFF_MEM_CLEAR_ON_RESET_EN
    check_output("rd 20 after rst", bus.uo_out, 8'h00);
`else
    check_output("rd 20 after rst", bus.uo_out, 8'h99);
`endif
    apply_stimulus(1'b1, 1'b0, 1'b0, 7'h20, 8'h00);
    check_output("rst with ena0", bus.uo_out, 8'h00);

    // Full sweep: distinct data per address exposes any aliasing.
    for (int i = 0; i < 128; i++) begin
      pattern = 8'(i) ^ 8'h55;
      apply_stimulus(1'b0, 1'b1, 1'b1, 7'(i), pattern);
      check_output($sformatf("sweep wr %02h", i), bus.uo_out, pattern);
    end
    for (int i = 0; i < 128; i++) begin
      pattern = 8'(i) ^ 8'h55;
      apply_stimulus(1'b0, 1'b1, 1'b0, 7'(i), 8'h00);
      check_output($sformatf("sweep rd %02h", i), bus.uo_out, pattern);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
